// File: rtl/wdt_ctrl_pkg.sv
// wdt_ctrl_pkg: shared types and constants for the watchdog sequencer.
// Holds the state enum, parameter defaults and STATUS bit reset values.
package wdt_ctrl_pkg;

   localparam int SYNC_STAGES_DEF   = 2;
   localparam int RST_PULSE_LEN_DEF = 4;

   localparam logic TO_N_RST = 1'b1;
   localparam logic PD_N_RST = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SLEEP = 2'd1,
      ST_TRIP  = 2'd2
   } wdt_state_t;

endpackage

// File: rtl/wdt_ctrl_toggle_sync.sv
// toggle_sync: multi-flop synchronizer with a one-cycle change strobe.
// Ports: clk_wdt, rst (sync, high), din (async level/toggle),
//        level (synchronized din), chg (high one cycle per din change).
module toggle_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_wdt,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic chg
);

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk_wdt) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= sync[STAGES-1];
      end
   end

   assign level = sync[STAGES-1];
   assign chg   = sync[STAGES-1] ^ prev;

endmodule

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: watchdog sequencer (CLRWDT/SLEEP handshakes, trip, wake, TO/PD).
// Ports: clk_wdt, rst (sync, high), wdt_en, clrwdt_req, sleep_req, ext_wake,
//        wdt_timeout in; wdt_clr, req_ack, sleep_mode, wake, wdt_rst,
//        to_n, pd_n out. Macro WDT_CTRL_EXT_WAKE_EN builds the ext_wake path.
module wdt_ctrl
   import wdt_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int RST_PULSE_LEN = RST_PULSE_LEN_DEF
) (
   input  logic clk_wdt,
   input  logic rst,
   input  logic wdt_en,
   input  logic clrwdt_req,
   input  logic sleep_req,
   input  logic ext_wake,
   input  logic wdt_timeout,
   output logic wdt_clr,
   output logic req_ack,
   output logic sleep_mode,
   output logic wake,
   output logic wdt_rst,
   output logic to_n,
   output logic pd_n
);

   wdt_state_t state;
   logic [3:0] cnt;
   logic       ack_due;
   logic       clr_pend;
   logic       slp_pend;
   logic       to_q;

   logic clr_chg;
   logic slp_chg;
   logic clr_lvl_unused;
   logic slp_lvl_unused;
   logic ext_lvl;

   logic clr_any;
   logic slp_any;
   logic to_fire;

   toggle_sync #(.STAGES(SYNC_STAGES)) u_clr_sync (
      .clk_wdt (clk_wdt),
      .rst     (rst),
      .din     (clrwdt_req),
      .level   (clr_lvl_unused),
      .chg     (clr_chg)
   );

   toggle_sync #(.STAGES(SYNC_STAGES)) u_slp_sync (
      .clk_wdt (clk_wdt),
      .rst     (rst),
      .din     (sleep_req),
      .level   (slp_lvl_unused),
      .chg     (slp_chg)
   );

`ifdef WDT_CTRL_EXT_WAKE_EN
   logic ext_chg_unused;

   toggle_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
      .clk_wdt (clk_wdt),
      .rst     (rst),
      .din     (ext_wake),
      .level   (ext_lvl),
      .chg     (ext_chg_unused)
   );
`else
   logic ext_unused;

   assign ext_lvl    = 1'b0;
   assign ext_unused = ext_wake;
`endif

   // Requests held during TRIP merge with fresh ones in the first RUN cycle.
   assign clr_any = clr_chg | clr_pend;
   assign slp_any = slp_chg | slp_pend;
   assign to_fire = wdt_timeout & ~to_q & wdt_en;

   always_ff @(posedge clk_wdt) begin
      if (rst) begin
         state      <= ST_RUN;
         cnt        <= '0;
         ack_due    <= 1'b0;
         clr_pend   <= 1'b0;
         slp_pend   <= 1'b0;
         to_q       <= 1'b0;
         wdt_clr    <= 1'b0;
         req_ack    <= 1'b0;
         sleep_mode <= 1'b0;
         wake       <= 1'b0;
         wdt_rst    <= 1'b0;
         to_n       <= TO_N_RST;
         pd_n       <= PD_N_RST;
      end else begin
         to_q    <= wdt_timeout;
         wdt_clr <= 1'b0;
         wake    <= 1'b0;
         // One ack toggle covers every request serviced on the prior edge.
         ack_due <= 1'b0;
         req_ack <= req_ack ^ ack_due;

         case (state)
            ST_RUN: begin
               clr_pend <= 1'b0;
               slp_pend <= 1'b0;
               if (slp_any) begin
                  wdt_clr    <= 1'b1;
                  to_n       <= 1'b1;
                  pd_n       <= 1'b0;
                  sleep_mode <= 1'b1;
                  ack_due    <= 1'b1;
                  state      <= ST_SLEEP;
               end else if (clr_any) begin
                  // A clear in the same cycle swallows the timeout.
                  wdt_clr <= 1'b1;
                  to_n    <= 1'b1;
                  pd_n    <= 1'b1;
                  ack_due <= 1'b1;
               end else if (to_fire) begin
                  to_n    <= 1'b0;
                  wdt_rst <= 1'b1;
                  wdt_clr <= 1'b1;
                  cnt     <= 4'(RST_PULSE_LEN - 1);
                  state   <= ST_TRIP;
               end
            end

            ST_SLEEP: begin
               ack_due <= clr_chg | slp_chg;
               if (to_fire) begin
                  to_n       <= 1'b0;
                  wake       <= 1'b1;
                  sleep_mode <= 1'b0;
                  state      <= ST_RUN;
               end else if (ext_lvl) begin
                  wake       <= 1'b1;
                  sleep_mode <= 1'b0;
                  state      <= ST_RUN;
               end
            end

            ST_TRIP: begin
               clr_pend <= clr_pend | clr_chg;
               slp_pend <= slp_pend | slp_chg;
               if (cnt == 4'd0) begin
                  wdt_rst <= 1'b0;
                  state   <= ST_RUN;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Watchdog sequencing controller on the `clk_wdt` domain, next to the TMR0/WDT timer block. It takes CLRWDT and SLEEP requests from the core clock domain through toggle handshakes, and drives the timer's watchdog-clear strobe. It interprets watchdog timeouts as either a device-reset request or a wake from sleep, and maintains the STATUS `TO`/`PD` bits.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for the core-domain inputs. Legal range 2–4.
- `RST_PULSE_LEN`, default 4: width of `wdt_rst` in `clk_wdt` cycles. Legal range 1–15.

Ports (name, direction, width, meaning):
- `clk_wdt` in 1: watchdog clock. All state is on its rising edge.
- `rst` in 1: power-on reset. Synchronous, active-high. The `wdt_rst` output never feeds back into it.
- `wdt_en` in 1: config fuse. 1 = watchdog timeouts are acted on.
- `clrwdt_req` in 1: toggle from the core domain. Each change is one CLRWDT request.
- `sleep_req` in 1: toggle from the core domain. Each change is one SLEEP request.
- `ext_wake` in 1: level wake source from the core domain (interrupt or pin).
- `wdt_timeout` in 1: timeout from the timer block. May be several cycles wide.
- `wdt_clr` out 1: one-cycle clear strobe to the timer block.
- `req_ack` out 1: toggles once per processed CLRWDT or SLEEP request.
- `sleep_mode` out 1: 1 while the device is asleep.
- `wake` out 1: one-cycle wake strobe to the core.
- `wdt_rst` out 1: device-reset request, stretched to `RST_PULSE_LEN` cycles.
- `to_n` out 1: STATUS TO bit, active-low.
- `pd_n` out 1: STATUS PD bit, active-low.

## Operation
- **Input synchronization:** `clrwdt_req`, `sleep_req` and `ext_wake` each pass through `SYNC_STAGES` flops.
  - A request is the XOR of the last synchronized stage and its registered copy.
  - `wdt_timeout` is already in this domain. Its rising edge is detected with one register.
- **States:** RUN, SLEEP, TRIP.
- **RUN:**
  - CLRWDT request: pulse `wdt_clr`; set `to_n`=1, `pd_n`=1; toggle `req_ack`.
  - SLEEP request: pulse `wdt_clr`; set `to_n`=1, `pd_n`=0; raise `sleep_mode`; go to SLEEP; toggle `req_ack`.
  - Timeout edge with `wdt_en`=1: set `to_n`=0 and go to TRIP.
- **SLEEP:**
  - Timeout edge with `wdt_en`=1: set `to_n`=0 (`pd_n` stays 0); pulse `wake`; drop `sleep_mode`; go to RUN. No reset is requested.
  - `ext_wake` high: pulse `wake`; drop `sleep_mode`; go to RUN. Status bits are unchanged.
  - CLRWDT and SLEEP requests are acked but have no other effect.
- **TRIP:**
  - Hold `wdt_rst`=1 for `RST_PULSE_LEN` cycles using a 4-bit down-counter.
  - Pulse `wdt_clr` in the first TRIP cycle.
  - Return to RUN when the counter reaches zero.
  - Requests arriving during TRIP are held pending, not lost, and are serviced in the first RUN cycle.
- **Simultaneous events:**
  - CLRWDT and timeout in the same cycle: the clear wins and the timeout is discarded.
  - SLEEP and CLRWDT in the same cycle: SLEEP is processed, then both are acked with a single `req_ack` toggle.
  - In SLEEP, timeout and `ext_wake` together: treated as a timeout wake (`to_n`=0).
- **`wdt_en`=0:** all timeouts are ignored. Requests and status-bit updates still operate.
- **Reset values:** state RUN, `wdt_clr`=0, `req_ack`=0, `sleep_mode`=0, `wake`=0, `wdt_rst`=0, `to_n`=1, `pd_n`=1. All synchronizer flops are cleared.
- **Reset mid-operation:** `rst` during TRIP or SLEEP aborts immediately to the reset values.

## Timing
- **Request to `wdt_clr`:** a request toggle present before edge 0 produces `wdt_clr` high in the cycle after edge `SYNC_STAGES`+1. That is edge 3 with defaults.
- **Status bits and state:** update on the same edge that asserts `wdt_clr`.
- **`req_ack`:** toggles one edge after `wdt_clr` is asserted.
- **Timeout:** a `wdt_timeout` rising edge at edge N gives the TRIP entry (or the `wake` strobe) at edge N+1. `wdt_rst` is high for edges N+1 through N+`RST_PULSE_LEN`.
- **`ext_wake`:** `wake` rises `SYNC_STAGES`+1 edges after `ext_wake` goes high.
- **Pulse widths:** `wake` and `wdt_clr` are always exactly one cycle wide.

## Configuration
- Macro `WDT_CTRL_EXT_WAKE_EN`.
- Defined: the `ext_wake` synchronizer and the SLEEP exit path via `ext_wake` are built as described above.
- Undefined: `ext_wake` is ignored and no synchronizer is instantiated. SLEEP exits only on a watchdog timeout, and only when `wdt_en`=1; otherwise SLEEP is permanent until `rst`.
- The port list is identical in both builds.

## Structure
- Package `wdt_ctrl_pkg` holds:
  - the state enum (RUN, SLEEP, TRIP);
  - the parameter defaults;
  - the reset values of `to_n` and `pd_n`.
- Sub-module `toggle_sync`, parameterized by `SYNC_STAGES`:
  - outputs the synchronized level and a one-cycle change strobe;
  - is instantiated for `clrwdt_req`, `sleep_req` and `ext_wake`.

## Test plan
- Flip `clrwdt_req` after reset → `wdt_clr` pulses at edge 3; `to_n`=1, `pd_n`=1; `req_ack` toggles at edge 4.
- Flip `sleep_req`, then raise `wdt_timeout` for 3 cycles with `wdt_en`=1 → `sleep_mode`=1 and `pd_n`=0; then `wake` pulses once with `to_n`=0, `pd_n`=0, and `wdt_rst` never asserts.
- In RUN, raise `wdt_timeout` at edge 10 with `RST_PULSE_LEN`=4 → `wdt_rst` high on edges 11–14, `to_n`=0, `wdt_clr` pulses at edge 11, state returns to RUN.
- Synchronized CLRWDT and timeout edge land on the same cycle → `wdt_clr` pulses, no `wdt_rst`, `to_n`=1.
- Set `wdt_en`=0 and pulse `wdt_timeout` in RUN and in SLEEP → no `wdt_rst`, no `wake`, status bits unchanged.
- With `WDT_CTRL_EXT_WAKE_EN` defined, raise `ext_wake` in SLEEP → `wake` at edge 3, `pd_n` stays 0, `to_n` stays 1. Assert `rst` during TRIP → all outputs return to reset values on the next edge.
